// File: rtl/core_control.sv
// Multi-cycle control sequencer: fetches 9-bit instructions, issues them to the
// 8-bit ALU, writes results back to the register file and resolves branches/HALT.
module core_control #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pc,
    input  logic [8:0]      instr,
    output logic [2:0]      rf_raddr_a,
    output logic [2:0]      rf_raddr_b,
    input  logic [7:0]      rf_rdata_a,
    input  logic [7:0]      rf_rdata_b,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic [7:0]      rf_wdata,
    output logic [5:0]      alu_opcode,
    output logic [7:0]      alu_in1,
    output logic [7:0]      alu_in2,
    input  logic [7:0]      alu_result,
    input  logic            alu_overflow,
    output logic            flag,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_WB,
        S_HALTED
    } state_e;

    state_e          state_q, state_d;
    logic [8:0]      ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_q, flag_d;
    logic            halted_q, halted_d;

    logic [2:0]      op, fn, rr;
    logic            is_r, is_a, is_b, is_halt, is_alu;
    logic            wb_op, flag_op, br_taken;
    logic [PC_W-1:0] pc_inc, br_off;

    always_comb begin
        op       = ir_q[8:6];
        fn       = ir_q[5:3];
        rr       = ir_q[2:0];
        is_r     = op inside {3'b010, 3'b011, 3'b100, 3'b101};
        is_a     = (op == 3'b110);
        is_b     = (op == 3'b111);
        is_halt  = is_a && (fn == 3'b111);
        is_alu   = is_r || (is_a && (fn <= 3'b101));
        wb_op    = (op == 3'b010) || (op == 3'b101) ||
                   (is_a && (fn inside {3'b000, 3'b001, 3'b010, 3'b101}));
        flag_op  = (op inside {3'b010, 3'b011, 3'b100}) ||
                   (is_a && (fn inside {3'b000, 3'b011, 3'b100}));
        br_taken = is_b && (((fn == 3'b000) && !flag_q) ||
                            ((fn == 3'b001) && flag_q));
        pc_inc   = pc_q + PC_W'(1);
        br_off   = {{(PC_W-3){rr[2]}}, rr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            pc_q     <= '0;
            flag_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            flag_q   <= flag_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        flag_d     = flag_q;
        halted_d   = halted_q;
        rf_raddr_a = fn;
        rf_raddr_b = rr;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        alu_opcode = '0;
        alu_in1    = '0;
        alu_in2    = '0;

        unique case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (is_alu) begin
                    // Only real ALU ops reach the ALU; NOPs and branches keep it idle.
                    alu_opcode = is_r ? {op, 3'b000} : {op, fn};
                    alu_in1    = is_r ? rf_rdata_a : '0;
                    alu_in2    = rf_rdata_b;
                    state_d    = S_WB;
                end else if (is_halt) begin
                    halted_d = 1'b1;
                    state_d  = S_HALTED;
                end else begin
                    pc_d    = br_taken ? (pc_inc + br_off) : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                rf_we    = wb_op;
                rf_waddr = is_r ? fn : rr;
                rf_wdata = alu_result;
                if (flag_op) begin
                    flag_d = alu_overflow;
                end
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    assign pc     = pc_q;
    assign flag   = flag_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_core_control.sv
// Scoreboarded bench for core_control with a behavioural ROM, register file and ALU.
module tb_core_control;

    logic       clk;
    logic       reset;
    logic [7:0] pc;
    logic [8:0] instr;
    logic [2:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic       rf_we;
    logic [5:0] alu_opcode;
    logic [7:0] alu_in1, alu_in2, alu_result;
    logic       alu_overflow;
    logic       flag, halted;

    logic [8:0] rom [0:255];
    logic [7:0] rf [0:7];
    logic [7:0] rf_init [0:7];
    logic       rf_load;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    int checks;
    int failures;

    core_control #(.PC_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr       (instr),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_opcode  (alu_opcode),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_result  (alu_result),
        .alu_overflow(alu_overflow),
        .flag        (flag),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr      = rom[pc];
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Behavioural ALU: registered result, holds state on undecoded opcodes.
    always @(posedge clk) begin
        case (alu_opcode)
            6'b010000: {alu_overflow, alu_result} <= {1'b0, alu_in1} + {1'b0, alu_in2};
            6'b011000: alu_overflow <= (alu_in1 == alu_in2);
            6'b100000: alu_overflow <= (alu_in1 < alu_in2);
            6'b101000: begin
                alu_result   <= (alu_in1 > alu_in2) ? alu_in1 - alu_in2 : alu_in2 - alu_in1;
                alu_overflow <= 1'b0;
            end
            6'b110000: {alu_overflow, alu_result} <= {alu_in2, 1'b0};
            6'b110001: {alu_result, alu_overflow} <= {1'b0, alu_in2};
            6'b110010: begin
                alu_result   <= alu_in2 + 8'd1;
                alu_overflow <= (alu_in2 == 8'hFF);
            end
            6'b110011: alu_overflow <= alu_in2[0];
            6'b110100: alu_overflow <= (alu_in2 == 8'h00);
            6'b110101: alu_result <= 8'h00;
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (!reset && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_write unexpected: waddr=%0d wdata=%h required no write",
                         rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_waddr !== e.a || rf_wdata !== e.d) begin
                    failures++;
                    $display("FAIL sb_write actual waddr=%0d wdata=%h required waddr=%0d wdata=%h",
                             rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
    end

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] f,
                                       input logic [2:0] r);
        return {op, f, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic hold_reset(input logic load);
        reset   = 1'b1;
        rf_load = load;
        repeat (2) @(posedge clk);
        rf_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_prog;
        for (int i = 0; i < 256; i++) rom[i] = ins(3'b110, 3'b111, 3'b000);
        for (int i = 0; i < 8; i++) rf_init[i] = 8'h00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rf_load  = 1'b0;

        // Program 1: ALU ops, flag handling, branches, NOP kinds, HALT
        clear_prog();
        rf_init[1] = 8'hF0; rf_init[2] = 8'h20; rf_init[3] = 8'h05; rf_init[4] = 8'h09;
        rom[8'h00] = ins(3'b010, 3'd1, 3'd2);
        rom[8'h01] = ins(3'b101, 3'd3, 3'd4);
        rom[8'h02] = ins(3'b110, 3'b100, 3'd4);
        rom[8'h03] = ins(3'b100, 3'd3, 3'd4);
        rom[8'h04] = ins(3'b111, 3'b000, 3'b011);
        rom[8'h05] = ins(3'b111, 3'b001, 3'b011);
        rom[8'h09] = ins(3'b110, 3'b110, 3'b000);
        rom[8'h0A] = ins(3'b111, 3'b010, 3'b101);
        rom[8'h0B] = ins(3'b001, 3'b101, 3'b101);
        rom[8'h0C] = ins(3'b111, 3'b001, 3'b011);
        rom[8'h10] = ins(3'b111, 3'b001, 3'b101);
        rom[8'h0E] = ins(3'b111, 3'b000, 3'b101);
        rom[8'h0F] = ins(3'b111, 3'b001, 3'b010);
        push(3'd1, 8'h10);
        push(3'd3, 8'h04);

        reset   = 1'b1;
        rf_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_in1", 32'(alu_in1), 32'd0);
        chk("rst_in2", 32'(alu_in2), 32'd0);
        rf_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        cyc(1);
        chk("add_issue_opcode", 32'(alu_opcode), 32'b010000);
        chk("add_issue_in1", 32'(alu_in1), 32'hF0);
        chk("add_issue_in2", 32'(alu_in2), 32'h20);
        cyc(2);
        chk("add_pc", 32'(pc), 32'h01);
        chk("add_flag", 32'(flag), 32'd1);
        cyc(3);
        chk("dist_pc", 32'(pc), 32'h02);
        chk("dist_flag_kept", 32'(flag), 32'd1);
        cyc(3);
        chk("eqz_flag", 32'(flag), 32'd0);
        cyc(3);
        chk("lt_pc", 32'(pc), 32'h04);
        chk("lt_flag", 32'(flag), 32'd1);
        cyc(2);
        chk("bno_not_taken_pc", 32'(pc), 32'h05);
        cyc(2);
        chk("bof_taken_pc", 32'(pc), 32'h09);
        cyc(2);
        chk("nop_tbd_pc", 32'(pc), 32'h0A);
        cyc(2);
        chk("nop_bfunc_pc", 32'(pc), 32'h0B);
        cyc(2);
        chk("nop_op001_pc", 32'(pc), 32'h0C);
        cyc(2);
        chk("bof_fwd_pc", 32'(pc), 32'h10);
        cyc(2);
        chk("bof_back_pc", 32'(pc), 32'h0E);
        cyc(2);
        chk("bno_back_pc", 32'(pc), 32'h0F);
        chk("nop_flag_kept", 32'(flag), 32'd1);
        cyc(2);
        chk("bof_p2_pc", 32'(pc), 32'h12);
        cyc(2);
        chk("halt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("halt_pc_frozen", 32'(pc), 32'h12);
            chk("halt_opcode_idle", 32'(alu_opcode), 32'd0);
        end
        chk("p1_sb_drained", 32'(exp_q.size()), 32'd0);

        // Program 2: PC wrap in both directions
        clear_prog();
        rf_init[1] = 8'hF0; rf_init[2] = 8'h20;
        rom[8'h00] = ins(3'b010, 3'd1, 3'd2);
        rom[8'h01] = ins(3'b111, 3'b001, 3'b100);
        rom[8'hFE] = ins(3'b111, 3'b001, 3'b000);
        rom[8'hFF] = ins(3'b000, 3'b000, 3'b000);
        push(3'd1, 8'h10);
        push(3'd1, 8'h30);
        hold_reset(1'b1);
        chk("halt_reset_pc", 32'(pc), 32'h00);
        chk("halt_reset_halted", 32'(halted), 32'd0);
        cyc(3);
        chk("p2_add_flag", 32'(flag), 32'd1);
        cyc(2);
        chk("wrap_neg_pc", 32'(pc), 32'hFE);
        cyc(2);
        chk("bof_zero_off_pc", 32'(pc), 32'hFF);
        cyc(2);
        chk("wrap_pos_pc", 32'(pc), 32'h00);
        cyc(3);
        chk("p2_add2_flag", 32'(flag), 32'd0);
        cyc(2);
        chk("bof_flag0_pc", 32'(pc), 32'h02);
        cyc(2);
        chk("p2_halted", 32'(halted), 32'd1);
        chk("p2_sb_drained", 32'(exp_q.size()), 32'd0);

        // Program 3: reset during INCR writeback, then a clean re-run
        clear_prog();
        rf_init[1] = 8'hF0; rf_init[2] = 8'h20; rf_init[5] = 8'h41;
        rom[8'h00] = ins(3'b010, 3'd1, 3'd2);
        rom[8'h01] = ins(3'b110, 3'b010, 3'd5);
        push(3'd1, 8'h10);
        hold_reset(1'b1);
        cyc(3);
        chk("p3_add_flag", 32'(flag), 32'd1);
        cyc(2);
        chk("incr_wb_we", 32'(rf_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_rf_we", 32'(rf_we), 32'd0);
        chk("abort_pc", 32'(pc), 32'h00);
        chk("abort_flag", 32'(flag), 32'd0);
        push(3'd1, 8'h30);
        push(3'd5, 8'h42);
        hold_reset(1'b0);
        chk("abort_r5_kept", 32'(rf[5]), 32'h41);
        cyc(3);
        chk("rerun_add_pc", 32'(pc), 32'h01);
        cyc(3);
        chk("rerun_incr_pc", 32'(pc), 32'h02);
        chk("rerun_r5", 32'(rf[5]), 32'h42);
        cyc(2);
        chk("rerun_halted", 32'(halted), 32'd1);
        chk("p3_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
